polaris_gpio_irq: RTL and testbench
===================================

# polaris_gpio_irq

Second-generation TileLink-UL GPIO slave: up to 32 pins, per-pin tristate control, atomic set/clear/toggle output writes, and per-pin edge/level interrupt detection with a W1C pending register and a single aggregated interrupt line. It sits on the peripheral TL-UL crossbar next to the timer and UART and drives the pad ring directly. It replaces the earlier GPIO and fixes its response opcode and interrupt-clear behaviour.

## Interface
- TL_RS, 4, width of a/d source fields
- NGPIO, 32, number of pins, 1..32
- SYNC_STAGES, 2, input synchroniser depth, 2..4
- gpio_clock_i  in  1  sole clock
- gpio_reset_ni  in  1  reset, asynchronous assert, active-low
- gpio_a_opcode/param/size/source/address/mask/data/corrupt  in  3/3/4/TL_RS/6/4/32/1  TL-UL A channel; param and corrupt are ignored
- gpio_a_valid  in  1; gpio_a_ready  out  1
- gpio_d_opcode/param/size/source/denied/data/corrupt  out  3/2/4/TL_RS/1/32/1  TL-UL D channel
- gpio_d_valid  out  1; gpio_d_ready  in  1
- outputs_o  out  NGPIO  pad output values
- t_o  out  NGPIO  tristate enables, 1 = pin is an input (high-Z)
- inputs_i  in  NGPIO  asynchronous pad inputs
- irq_o  out  1  level interrupt, OR of (PENDING & IE)

## Operation
- Registers use word offsets on address[5:2]. Bits at or above NGPIO read as 0; writes to those bits are ignored.
  - 0x00 IN (RO, synchronised input)
  - 0x04 OUT (RW)
  - 0x08 OUT_SET (WO)
  - 0x0C OUT_CLR (WO)
  - 0x10 OUT_TGL (WO)
  - 0x14 T (RW)
  - 0x18 IE (RW)
  - 0x1C RISE_EN
  - 0x20 FALL_EN
  - 0x24 HIGH_EN
  - 0x28 LOW_EN
  - 0x2C PENDING (RW1C)
  - 0x30–0x3C reserved: read 0, writes ignored, not denied
- Write-only registers read as 0.
- Accepted opcodes:
  - Get (4): AccessAckData (1)
  - PutFullData (0) and PutPartialData (1): AccessAck (0)
  - Any other opcode, or a_size > 2: AccessAck/AccessAckData by class, d_denied=1, no register side effect, d_data=0
- Writes apply a_mask per byte lane, for RW registers and for SET/CLR/TGL/W1C alike. A lane with mask 0 leaves its bits unaffected.
- Response fields:
  - d_size and d_source echo the request
  - d_param=0, d_corrupt=0
  - d_data=0 for AccessAck
- Input path: SYNC_STAGES-deep flop chain gives `s`; one more flop gives `prev`.
  - rise = s & ~prev
  - fall = ~s & prev
- Per-pin pending set term = (rise & RISE_EN) | (fall & FALL_EN) | (s & HIGH_EN) | (~s & LOW_EN).
- PENDING is set independently of IE.
- Level sources re-set PENDING every cycle while the level persists, so a W1C while the level is held has no lasting effect.
- irq_o is combinational from flops: |(PENDING & IE).

## Timing
- All outputs and internal registers reset asynchronously when gpio_reset_ni=0:
  - d_valid=0, all other D fields 0
  - OUT=0, T=all ones, IE/RISE_EN/FALL_EN/HIGH_EN/LOW_EN/PENDING=0
  - sync chain and prev=0
  - irq_o=0
- Reset asserted mid-transaction drops any pending response; no D beat is issued for it.
- Single response slot: gpio_a_ready = ~d_valid | gpio_d_ready.
- A beat accepted at edge N:
  - register writes take effect at edge N
  - d_valid is high from edge N through the edge where d_ready=1
- Back-to-back accepts are possible every cycle while d_ready=1, giving full throughput.
- D fields hold stable while d_valid & ~d_ready.
- Read data is sampled at the accept edge. A write at N followed by a read at N+1 returns the new value.
- Input latency:
  - a pin change before edge 0 is visible in IN after SYNC_STAGES edges
  - PENDING is set at edge SYNC_STAGES+1
  - irq_o rises in the same cycle PENDING is set
- A W1C and a set event for the same bit in the same cycle: the set wins, and the bit stays 1.
- OUT_TGL with all bits set inverts OUT in one cycle. SET, CLR and TGL never collide because only one write is accepted per cycle.

## Test plan
- Reset, then Get 0x14 -> AccessAckData with d_data=0x0000FFFF (NGPIO=16); t_o=0xFFFF; irq_o=0.
- PutFull OUT=0x00A5, then PutPartial OUT_SET data=0xFF00 mask=0b0010, then OUT_TGL 0x0001 -> outputs_o=0xFFA4; each put gives AccessAck with opcode 0.
- RISE_EN=0x0004, IE=0x0004, drive inputs_i[2] 0→1 -> PENDING=0x0004 at edge SYNC_STAGES+1 and irq_o=1; W1C 0x0004 -> PENDING=0, irq_o=0.
- HIGH_EN=0x0001 with inputs_i[0] held high, W1C PENDING=0x0001 -> PENDING reads 0x0001 on the next Get; drop the input, then W1C -> PENDING=0.
- Hold d_ready=0 for 5 cycles after a Get -> a_ready=0, D fields stable; release -> one beat only. Issue a Get with opcode 2 (Arithmetic) -> d_denied=1, no state change.
- Assert gpio_reset_ni while d_valid=1 -> d_valid drops immediately without waiting for a clock edge; no stale beat appears after release.

Source files
------------

// File: rtl/polaris_gpio_irq_if.sv
// TileLink-UL A/D channel bundle between the peripheral crossbar and polaris_gpio_irq.
// The crossbar side is the master; the GPIO block is the slave.
interface polaris_gpio_irq_if #(
    parameter int TL_RS = 4
) ();
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [3:0]       a_size;
    logic [TL_RS-1:0] a_source;
    logic [5:0]       a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             a_corrupt;
    logic             a_valid;
    logic             a_ready;

    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [3:0]       d_size;
    logic [TL_RS-1:0] d_source;
    logic             d_denied;
    logic [31:0]      d_data;
    logic             d_corrupt;
    logic             d_valid;
    logic             d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready
    );
endinterface

// File: rtl/polaris_gpio_irq.sv
// TL-UL GPIO slave: tristate pads, atomic set/clear/toggle output writes, and
// per-pin edge/level interrupt capture into a W1C pending register with one irq line.
module polaris_gpio_irq #(
    parameter int TL_RS       = 4,
    parameter int NGPIO       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               gpio_clock_i,
    input  logic               gpio_reset_ni,
    polaris_gpio_irq_if.slave  gpio,
    output logic [NGPIO-1:0]   outputs_o,
    output logic [NGPIO-1:0]   t_o,
    input  logic [NGPIO-1:0]   inputs_i,
    output logic               irq_o
);
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    localparam logic [3:0] REG_IN      = 4'd0;
    localparam logic [3:0] REG_OUT     = 4'd1;
    localparam logic [3:0] REG_OUT_SET = 4'd2;
    localparam logic [3:0] REG_OUT_CLR = 4'd3;
    localparam logic [3:0] REG_OUT_TGL = 4'd4;
    localparam logic [3:0] REG_T       = 4'd5;
    localparam logic [3:0] REG_IE      = 4'd6;
    localparam logic [3:0] REG_RISE_EN = 4'd7;
    localparam logic [3:0] REG_FALL_EN = 4'd8;
    localparam logic [3:0] REG_HIGH_EN = 4'd9;
    localparam logic [3:0] REG_LOW_EN  = 4'd10;
    localparam logic [3:0] REG_PENDING = 4'd11;

    logic [NGPIO-1:0] out_q;
    logic [NGPIO-1:0] t_q;
    logic [NGPIO-1:0] ie_q;
    logic [NGPIO-1:0] rise_en_q;
    logic [NGPIO-1:0] fall_en_q;
    logic [NGPIO-1:0] high_en_q;
    logic [NGPIO-1:0] low_en_q;
    logic [NGPIO-1:0] pending_q;

    logic [NGPIO-1:0] sync_q [SYNC_STAGES];
    logic [NGPIO-1:0] prev_q;
    logic [NGPIO-1:0] sync_in;

    logic             d_valid_q;
    logic [2:0]       d_opcode_q;
    logic [3:0]       d_size_q;
    logic [TL_RS-1:0] d_source_q;
    logic             d_denied_q;
    logic [31:0]      d_data_q;

    logic             accept;
    logic             is_get;
    logic             is_put;
    logic             legal;
    logic             do_write;
    logic             ack_with_data;
    logic [3:0]       reg_idx;
    logic [31:0]      lane_mask;
    logic [NGPIO-1:0] wmask;
    logic [NGPIO-1:0] wbits;
    logic [NGPIO-1:0] w1c_bits;
    logic [NGPIO-1:0] set_evt;
    logic [31:0]      rd_word;
    logic             unused_tl;

    assign gpio.a_ready = ~d_valid_q | gpio.d_ready;
    assign accept       = gpio.a_valid & gpio.a_ready;
    assign is_get       = (gpio.a_opcode == OP_GET);
    assign is_put       = (gpio.a_opcode == OP_PUT_FULL) | (gpio.a_opcode == OP_PUT_PARTIAL);
    assign legal        = (is_get | is_put) & (gpio.a_size <= 4'd2);
    assign do_write     = accept & is_put & legal;
    // Denied requests still answer with the ack flavour their opcode class expects.
    assign ack_with_data = (gpio.a_opcode == OP_ARITH) | (gpio.a_opcode == OP_LOGIC) | is_get;
    assign reg_idx      = gpio.a_address[5:2];

    assign lane_mask = {{8{gpio.a_mask[3]}}, {8{gpio.a_mask[2]}},
                        {8{gpio.a_mask[1]}}, {8{gpio.a_mask[0]}}};
    assign wmask     = lane_mask[NGPIO-1:0];
    assign wbits     = gpio.a_data[NGPIO-1:0] & wmask;
    assign w1c_bits  = (do_write && reg_idx == REG_PENDING) ? wbits : '0;

    assign unused_tl = ^{gpio.a_param, gpio.a_corrupt, gpio.a_address[1:0], gpio.a_data, lane_mask};

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign set_evt = (sync_in & ~prev_q & rise_en_q) |
                     (~sync_in & prev_q & fall_en_q) |
                     (sync_in & high_en_q) |
                     (~sync_in & low_en_q);

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_IN:      rd_word = 32'(sync_in);
            REG_OUT:     rd_word = 32'(out_q);
            REG_T:       rd_word = 32'(t_q);
            REG_IE:      rd_word = 32'(ie_q);
            REG_RISE_EN: rd_word = 32'(rise_en_q);
            REG_FALL_EN: rd_word = 32'(fall_en_q);
            REG_HIGH_EN: rd_word = 32'(high_en_q);
            REG_LOW_EN:  rd_word = 32'(low_en_q);
            REG_PENDING: rd_word = 32'(pending_q);
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
        if (!gpio_reset_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= inputs_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_in;
        end
    end

    always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
        if (!gpio_reset_ni) begin
            out_q     <= '0;
            t_q       <= '1;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            high_en_q <= '0;
            low_en_q  <= '0;
            pending_q <= '0;
        end else begin
            if (do_write) begin
                case (reg_idx)
                    REG_OUT:     out_q     <= (out_q & ~wmask) | wbits;
                    REG_OUT_SET: out_q     <= out_q | wbits;
                    REG_OUT_CLR: out_q     <= out_q & ~wbits;
                    REG_OUT_TGL: out_q     <= out_q ^ wbits;
                    REG_T:       t_q       <= (t_q & ~wmask) | wbits;
                    REG_IE:      ie_q      <= (ie_q & ~wmask) | wbits;
                    REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                    REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                    REG_HIGH_EN: high_en_q <= (high_en_q & ~wmask) | wbits;
                    REG_LOW_EN:  low_en_q  <= (low_en_q & ~wmask) | wbits;
                    default: ;
                endcase
            end
            // A fresh event outranks a same-cycle W1C of the same bit.
            pending_q <= (pending_q & ~w1c_bits) | set_evt;
        end
    end

    always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
        if (!gpio_reset_ni) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else if (accept) begin
            d_valid_q  <= 1'b1;
            d_opcode_q <= ack_with_data ? OP_ACK_DATA : OP_ACK;
            d_size_q   <= gpio.a_size;
            d_source_q <= gpio.a_source;
            d_denied_q <= ~legal;
            d_data_q   <= (legal && is_get) ? rd_word : '0;
        end else if (gpio.d_ready) begin
            d_valid_q  <= 1'b0;
        end
    end

    assign gpio.d_valid   = d_valid_q;
    assign gpio.d_opcode  = d_opcode_q;
    assign gpio.d_param   = '0;
    assign gpio.d_size    = d_size_q;
    assign gpio.d_source  = d_source_q;
    assign gpio.d_denied  = d_denied_q;
    assign gpio.d_data    = d_data_q;
    assign gpio.d_corrupt = 1'b0;

    assign outputs_o = out_q;
    assign t_o       = t_q;
    assign irq_o     = |(pending_q & ie_q);
endmodule

// File: tb/tb_polaris_gpio_irq.sv
// Bench for polaris_gpio_irq: directed scenarios plus randomized register traffic
// checked against a register-map model.
module tb_polaris_gpio_irq;
    localparam int TL_RS = 4;
    localparam int NGPIO = 16;
    localparam int SS    = 2;
    localparam logic [31:0] PINS = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    polaris_gpio_irq_if #(.TL_RS(TL_RS)) bus ();
    logic [NGPIO-1:0] outputs;
    logic [NGPIO-1:0] t_pins;
    logic [NGPIO-1:0] inputs;
    logic             irq;

    polaris_gpio_irq #(.TL_RS(TL_RS), .NGPIO(NGPIO), .SYNC_STAGES(SS)) dut (
        .gpio_clock_i (clk),
        .gpio_reset_ni(rst_n),
        .gpio         (bus),
        .outputs_o    (outputs),
        .t_o          (t_pins),
        .inputs_i     (inputs),
        .irq_o        (irq)
    );

    int checks = 0;
    int failures = 0;
    int beats = 0;

    always @(posedge clk) if (rst_n && bus.d_valid && bus.d_ready) beats++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model state
    logic [31:0] m_out, m_t, m_ie, m_rise, m_fall, m_high, m_low, m_pend, m_in;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        logic [31:0] r = 0;
        for (int b = 0; b < 4; b++) if (m[b]) r = r | (32'hFF << (8 * b));
        return r & PINS;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return m_in;
            1: return m_out;
            5: return m_t;
            6: return m_ie;
            7: return m_rise;
            8: return m_fall;
            9: return m_high;
            10: return m_low;
            11: return m_pend;
            default: return 0;
        endcase
    endfunction

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] lm = lane_bits(mask);
        logic [31:0] v = data & lm;
        case (idx)
            1: m_out = (m_out & ~lm) | v;
            2: m_out = m_out | v;
            3: m_out = m_out & ~v;
            4: m_out = m_out ^ v;
            5: m_t = (m_t & ~lm) | v;
            6: m_ie = (m_ie & ~lm) | v;
            7: m_rise = (m_rise & ~lm) | v;
            8: m_fall = (m_fall & ~lm) | v;
            9: m_high = (m_high & ~lm) | v;
            10: m_low = (m_low & ~lm) | v;
            11: m_pend = m_pend & ~v;
            default: ;
        endcase
        // inputs are static here, so only level sources can (re)assert pending
        m_pend = m_pend | (((m_in & m_high) | (~m_in & m_low)) & PINS);
    endtask

    task automatic bus_idle();
        bus.a_valid = 1'b0;
        bus.a_opcode = '0; bus.a_param = '0; bus.a_size = 4'd2; bus.a_source = '0;
        bus.a_address = '0; bus.a_mask = 4'hF; bus.a_data = '0; bus.a_corrupt = 1'b0;
        bus.d_ready = 1'b1;
    endtask

    // One A beat, response captured #1 after the accept edge, then one idle edge.
    task automatic xfer(input logic [2:0] op, input logic [5:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [3:0] size,
                        output logic [2:0] r_op, output logic r_den, output logic [31:0] r_data);
        logic [3:0] src;
        bit got;
        src = 4'($urandom);
        got = 1'b0;
        bus.a_opcode = op; bus.a_param = 3'($urandom); bus.a_size = size; bus.a_source = src;
        bus.a_address = addr; bus.a_mask = mask; bus.a_data = data; bus.a_corrupt = 1'($urandom);
        bus.a_valid = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = bus.a_ready;
            @(posedge clk);
        end
        #1 bus.a_valid = 1'b0;
        checks++;
        if (!got || bus.d_valid !== 1'b1 || bus.d_source !== src || bus.d_size !== size ||
            bus.d_param !== 2'd0 || bus.d_corrupt !== 1'b0) begin
            failures++;
            $display("FAIL xfer_handshake addr=%h accepted=%0d d_valid=%b d_source=%h exp %h d_size=%h exp %h param=%h corrupt=%b",
                     addr, got, bus.d_valid, bus.d_source, src, bus.d_size, size, bus.d_param, bus.d_corrupt);
        end
        r_op = bus.d_opcode; r_den = bus.d_denied; r_data = bus.d_data;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        logic [2:0] o; logic d; logic [31:0] r;
        xfer(3'd0, addr, data, 4'hF, 4'd2, o, d, r);
    endtask

    task automatic do_reset();
        bus_idle();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] o; logic d; logic [31:0] r;
        inputs = '0;
        do_reset();
        checks++;
        if (outputs !== 16'h0 || t_pins !== 16'hFFFF || irq !== 1'b0 || bus.d_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pins outputs=%h t=%h irq=%b d_valid=%b exp 0000/ffff/0/0", outputs, t_pins, irq, bus.d_valid);
        end
        xfer(3'd4, 6'h14, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd1 || d !== 1'b0 || r !== 32'h0000FFFF) begin
            failures++;
            $display("FAIL reset_read_t opcode=%0d denied=%b data=%h exp 1/0/0000ffff", o, d, r);
        end
    endtask

    task automatic test_out_ops();
        logic [2:0] o; logic d; logic [31:0] r;
        xfer(3'd0, 6'h04, 32'h00A5, 4'hF, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd0 || d !== 1'b0 || outputs !== 16'h00A5) begin
            failures++; $display("FAIL out_write opcode=%0d denied=%b outputs=%h exp 0/0/00a5", o, d, outputs);
        end
        xfer(3'd1, 6'h08, 32'hFF00, 4'b0010, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd0 || d !== 1'b0 || outputs !== 16'hFFA5) begin
            failures++; $display("FAIL out_set_partial opcode=%0d denied=%b outputs=%h exp 0/0/ffa5", o, d, outputs);
        end
        xfer(3'd0, 6'h10, 32'h0001, 4'hF, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd0 || outputs !== 16'hFFA4) begin
            failures++; $display("FAIL out_tgl opcode=%0d outputs=%h exp 0/ffa4", o, outputs);
        end
        wr(6'h10, 32'hFFFF_FFFF);
        checks++;
        if (outputs !== 16'h005B) begin
            failures++; $display("FAIL out_tgl_all outputs=%h exp 005b", outputs);
        end
        xfer(3'd1, 6'h0C, 32'h00FF, 4'b0010, 4'd2, o, d, r);
        checks++;
        if (outputs !== 16'h005B) begin
            failures++; $display("FAIL out_clr_masked_lane outputs=%h exp 005b", outputs);
        end
    endtask

    task automatic test_backpressure();
        int b0;
        bus.d_ready = 1'b0;
        bus.a_opcode = 3'd4; bus.a_size = 4'd2; bus.a_source = 4'h5; bus.a_address = 6'h04;
        bus.a_mask = 4'hF; bus.a_data = 32'h0; bus.a_valid = 1'b1;
        @(posedge clk); #1;
        bus.a_opcode = 3'd0; bus.a_source = 4'h9; bus.a_data = 32'h1234;
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.a_ready !== 1'b0 || bus.d_valid !== 1'b1 || bus.d_data !== 32'h005B ||
                bus.d_opcode !== 3'd1 || bus.d_source !== 4'h5 || bus.d_denied !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d a_ready=%b d_valid=%b data=%h opcode=%0d source=%h exp 0/1/005b/1/5",
                         i, bus.a_ready, bus.d_valid, bus.d_data, bus.d_opcode, bus.d_source);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (outputs !== 16'h005B) begin
            failures++; $display("FAIL stall_no_accept outputs=%h exp 005b", outputs);
        end
        bus.d_ready = 1'b1;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_opcode !== 3'd0 || bus.d_source !== 4'h9 || outputs !== 16'h1234) begin
            failures++;
            $display("FAIL stall_release d_valid=%b opcode=%0d source=%h outputs=%h exp 1/0/9/1234",
                     bus.d_valid, bus.d_opcode, bus.d_source, outputs);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (beats - b0 !== 2 || bus.d_valid !== 1'b0) begin
            failures++; $display("FAIL stall_beat_count beats=%0d d_valid=%b exp 2/0", beats - b0, bus.d_valid);
        end
    endtask

    task automatic test_denied();
        logic [2:0] o; logic d; logic [31:0] r;
        xfer(3'd2, 6'h04, 32'hDEAD, 4'hF, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd1 || d !== 1'b1 || r !== 32'h0 || outputs !== 16'h1234) begin
            failures++; $display("FAIL denied_arith opcode=%0d denied=%b data=%h outputs=%h exp 1/1/0/1234", o, d, r, outputs);
        end
        xfer(3'd0, 6'h04, 32'hBEEF, 4'hF, 4'd3, o, d, r);
        checks++;
        if (o !== 3'd0 || d !== 1'b1 || r !== 32'h0 || outputs !== 16'h1234) begin
            failures++; $display("FAIL denied_put_size opcode=%0d denied=%b data=%h outputs=%h exp 0/1/0/1234", o, d, r, outputs);
        end
        xfer(3'd4, 6'h04, 32'h0, 4'hF, 4'd3, o, d, r);
        checks++;
        if (o !== 3'd1 || d !== 1'b1 || r !== 32'h0) begin
            failures++; $display("FAIL denied_get_size opcode=%0d denied=%b data=%h exp 1/1/0", o, d, r);
        end
        xfer(3'd0, 6'h30, 32'hFFFF, 4'hF, 4'd2, o, d, r);
        xfer(3'd4, 6'h30, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (o !== 3'd1 || d !== 1'b0 || r !== 32'h0 || outputs !== 16'h1234 || t_pins !== 16'hFFFF) begin
            failures++; $display("FAIL reserved_rw opcode=%0d denied=%b data=%h outputs=%h t=%h exp 1/0/0/1234/ffff", o, d, r, outputs, t_pins);
        end
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        bus.a_opcode = 3'd0; bus.a_size = 4'd2; bus.a_address = 6'h04; bus.a_mask = 4'hF;
        bus.a_data = 32'h1111; bus.a_source = 4'h1; bus.a_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_opcode !== 3'd0 || outputs !== 16'h1111) begin
            failures++; $display("FAIL b2b_write d_valid=%b opcode=%0d outputs=%h exp 1/0/1111", bus.d_valid, bus.d_opcode, outputs);
        end
        bus.a_opcode = 3'd4; bus.a_source = 4'h2;
        @(posedge clk); #1;
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_opcode !== 3'd1 || bus.d_data !== 32'h1111 || bus.d_source !== 4'h2) begin
            failures++; $display("FAIL b2b_read_after_write d_valid=%b opcode=%0d data=%h source=%h exp 1/1/1111/2",
                                 bus.d_valid, bus.d_opcode, bus.d_data, bus.d_source);
        end
        bus.a_opcode = 3'd0; bus.a_address = 6'h10; bus.a_data = 32'hFFFF; bus.a_source = 4'h3;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        checks++;
        if (outputs !== 16'hEEEE || bus.d_opcode !== 3'd0 || bus.d_source !== 4'h3) begin
            failures++; $display("FAIL b2b_toggle outputs=%h opcode=%0d source=%h exp eeee/0/3", outputs, bus.d_opcode, bus.d_source);
        end
        @(posedge clk); #1;
        checks++;
        if (beats - b0 !== 3 || bus.d_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_beats beats=%0d d_valid=%b exp 3/0", beats - b0, bus.d_valid);
        end
    endtask

    task automatic test_edge_irq();
        logic [2:0] o; logic d; logic [31:0] r;
        wr(6'h1C, 32'h0004);
        wr(6'h18, 32'h0004);
        inputs[2] = 1'b1;
        for (int k = 1; k <= SS; k++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== 1'b0) begin
                failures++; $display("FAIL edge_irq_early edge=%0d irq=%b exp 0", k, irq);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL edge_irq_latency edge=%0d irq=%b exp 1", SS + 1, irq);
        end
        xfer(3'd4, 6'h2C, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (r !== 32'h0004) begin
            failures++; $display("FAIL edge_pending data=%h exp 00000004", r);
        end
        xfer(3'd4, 6'h00, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (r !== 32'h0004) begin
            failures++; $display("FAIL in_read data=%h exp 00000004", r);
        end
        wr(6'h2C, 32'h0004);
        xfer(3'd4, 6'h2C, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (r !== 32'h0 || irq !== 1'b0) begin
            failures++; $display("FAIL edge_w1c pending=%h irq=%b exp 0/0", r, irq);
        end
    endtask

    task automatic test_level();
        logic [2:0] o; logic d; logic [31:0] r;
        wr(6'h24, 32'h0001);
        inputs[0] = 1'b1;
        repeat (SS + 2) @(posedge clk);
        #1;
        wr(6'h2C, 32'h0001);
        xfer(3'd4, 6'h2C, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (r !== 32'h0001 || irq !== 1'b0) begin
            failures++; $display("FAIL level_w1c_held pending=%h irq=%b exp 00000001/0", r, irq);
        end
        inputs[0] = 1'b0;
        repeat (SS + 2) @(posedge clk);
        #1;
        wr(6'h2C, 32'h0001);
        xfer(3'd4, 6'h2C, 32'h0, 4'hF, 4'd2, o, d, r);
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL level_w1c_released pending=%h exp 0", r);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        bus.d_ready = 1'b0;
        bus.a_opcode = 3'd4; bus.a_size = 4'd2; bus.a_address = 6'h04; bus.a_source = 4'h7; bus.a_valid = 1'b1;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        checks++;
        if (bus.d_valid !== 1'b1) begin
            failures++; $display("FAIL rstmid_setup d_valid=%b exp 1", bus.d_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.d_valid !== 1'b0 || bus.d_data !== 32'h0 || outputs !== 16'h0 || t_pins !== 16'hFFFF) begin
            failures++; $display("FAIL rstmid_async d_valid=%b data=%h outputs=%h t=%h exp 0/0/0000/ffff",
                                 bus.d_valid, bus.d_data, outputs, t_pins);
        end
        #10;
        bus.d_ready = 1'b1;
        rst_n = 1'b1;
        b0 = beats;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (beats !== b0 || bus.d_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_stale beats=%0d d_valid=%b exp 0/0", beats - b0, bus.d_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0] o; logic d; logic [31:0] r;
        logic [2:0] op; logic [3:0] size; logic [3:0] mask; logic [31:0] data;
        logic [2:0] e_op; logic e_den; logic [31:0] e_data;
        int idx; bit lg; bit e_irq;
        inputs = 16'($urandom);
        do_reset();
        repeat (SS + 3) @(posedge clk);
        #1;
        m_out = 0; m_t = PINS; m_ie = 0; m_rise = 0; m_fall = 0; m_high = 0; m_low = 0; m_pend = 0;
        m_in = 32'(inputs);
        for (int it = 0; it < 150; it++) begin
            idx = $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0, 1, 2: op = 3'd0;
                3, 4, 5: op = 3'd1;
                6, 7, 8: op = 3'd4;
                default: op = 3'($urandom);
            endcase
            size = ($urandom_range(0, 7) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
            mask = 4'($urandom);
            data = $urandom;
            lg = (op == 3'd0 || op == 3'd1 || op == 3'd4) && size <= 4'd2;
            e_op = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 : 3'd0;
            e_den = !lg;
            e_data = (lg && op == 3'd4) ? model_read(idx) : 32'h0;
            xfer(op, {4'(idx), 2'($urandom)}, data, mask, size, o, d, r);
            if (lg && op != 3'd4) model_write(idx, data, mask);
            e_irq = |(m_pend & m_ie);
            checks++;
            if (o !== e_op || d !== e_den || r !== e_data) begin
                failures++; $display("FAIL rand_resp it=%0d op=%0d idx=%0d got %0d/%b/%h exp %0d/%b/%h",
                                     it, op, idx, o, d, r, e_op, e_den, e_data);
            end
            checks++;
            if (outputs !== m_out[15:0] || t_pins !== m_t[15:0] || irq !== e_irq) begin
                failures++; $display("FAIL rand_pins it=%0d outputs=%h t=%h irq=%b exp %h/%h/%b",
                                     it, outputs, t_pins, irq, m_out[15:0], m_t[15:0], e_irq);
            end
        end
    endtask

    initial begin
        bus_idle();
        inputs = '0;
        test_reset();
        test_out_ops();
        test_backpressure();
        test_denied();
        test_back_to_back();
        test_edge_irq();
        test_level();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
